// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the rv32 load/store unit and its request checker:
// funct3 access-size codes, mcause exception codes and the MEM-stage FSM
// state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RESP    = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_req_check.sv
// lsu_req_check
// Purely combinational legality, alignment and address-range check for one
// memory request. Shared between the load/store unit and the fetch side.
// Ports:
//   we     in  1   1=store, 0=load
//   funct3 in  3   RV32 access size/sign code
//   addr   in  32  byte address
//   exc    out 1   request raises an exception
//   cause  out 4   mcause code (0 when exc=0)
module lsu_req_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SPAN_LOG2 = 18
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        exc,
  output logic [3:0]  cause
);

  // Window size held one bit wider so a 32-bit span still compares correctly.
  localparam logic [32:0] SPAN = 33'd1 << SPAN_LOG2;

  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic [31:0] offset;

  // Illegal beats misaligned beats fault; unsigned funct3 has no store form.
  always_comb begin
    offset = addr - BASE_ADDR;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;
      default:          illegal = 1'b1;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    fault = ({1'b0, offset} >= SPAN);
    exc   = illegal | misaligned | fault;
    if (illegal)
      cause = CAUSE_ILLEGAL;
    else if (misaligned)
      cause = we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    else if (fault)
      cause = we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    else
      cause = 4'd0;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// rv32 MEM-stage load/store unit in front of the data RAM wrapper. Accepts
// one request per handshake, checks it, drives the RAM in the accept cycle,
// sign-extends the 1-cycle-latency read data and returns one registered
// response with a precise exception code.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_valid/req_ready       request handshake
//   req_we, req_funct3        store flag, access size/sign
//   req_addr, req_wdata       byte address, right-aligned store data
//   req_rd                    destination tag, echoed on rsp_rd
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata                 extended load data (0 for stores/exceptions)
//   rsp_exc, rsp_cause        exception flag and mcause code
//   ram_rwtyp/addr/data       RAM access type, window offset, store data
//   ram_wren, ram_rden        RAM strobes, only in a clean accept cycle
//   ram_q                     RAM read data, valid the cycle after ram_rden
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SPAN_LOG2 = 18
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_exc,
  output logic [3:0]  rsp_cause,
  output logic [2:0]  ram_rwtyp,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  output logic        ram_rden,
  input  logic [31:0] ram_q
);

  lsu_state_t  state;
  logic [2:0]  lat_funct3;
  logic        accept;
  logic        chk_exc;
  logic [3:0]  chk_cause;
  logic [31:0] load_ext;

  lsu_req_check #(
    .BASE_ADDR(BASE_ADDR),
    .SPAN_LOG2(SPAN_LOG2)
  ) u_check (
    .we    (req_we),
    .funct3(req_funct3),
    .addr  (req_addr),
    .exc   (chk_exc),
    .cause (chk_cause)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // The RAM sees the request directly in the accept cycle; strobes are
  // suppressed for excepting requests so no access is ever issued for them.
  assign ram_rwtyp = req_funct3;
  assign ram_addr  = req_addr - BASE_ADDR;
  assign ram_data  = req_wdata;
  assign ram_wren  = accept & req_we & ~chk_exc;
  assign ram_rden  = accept & ~req_we & ~chk_exc;

  // The RAM already zero-extends and lane-aligns; only signed b/h need work.
  always_comb begin
    case (lat_funct3)
      F3_B:    load_ext = {{24{ram_q[7]}}, ram_q[7:0]};
      F3_H:    load_ext = {{16{ram_q[15]}}, ram_q[15:0]};
      default: load_ext = ram_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_rd     <= 5'd0;
      rsp_exc    <= 1'b0;
      rsp_cause  <= 4'd0;
      lat_funct3 <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_rd <= req_rd;
            if (chk_exc || req_we) begin
              rsp_rdata <= 32'd0;
              rsp_exc   <= chk_exc;
              rsp_cause <= chk_cause;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              lat_funct3 <= req_funct3;
              state      <= LD_WAIT;
            end
          end
        end
        LD_WAIT: begin
          rsp_rdata <= load_ext;
          rsp_exc   <= 1'b0;
          rsp_cause <= 4'd0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl
// Directed self-checking bench for lsu_mem_ctrl with a small behavioural
// model of the data RAM wrapper (lane shifting, zero-extending, 1-cycle q).
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_exc;
  logic [3:0]  rsp_cause;
  logic [2:0]  ram_rwtyp;
  logic [31:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic        ram_rden;
  logic [31:0] ram_q;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int cnt_wren = 0;
  int cnt_rden = 0;

  logic [31:0] mem [0:1023];

  lsu_mem_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_rd    (rsp_rd),
    .rsp_exc   (rsp_exc),
    .rsp_cause (rsp_cause),
    .ram_rwtyp (ram_rwtyp),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .ram_rden  (ram_rden),
    .ram_q     (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM wrapper model: reads return the addressed lane zero-extended.
  function automatic logic [31:0] ramRead(input logic [31:0] word,
                                          input logic [2:0] typ,
                                          input logic [1:0] off);
    logic [31:0] sh;
    if (typ[1:0] == 2'b00) begin
      sh = word >> (8 * off);
      return {24'd0, sh[7:0]};
    end else if (typ[1:0] == 2'b01) begin
      sh = word >> (16 * off[1]);
      return {16'd0, sh[15:0]};
    end
    return word;
  endfunction

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (ram_wren) begin
      cnt_wren <= cnt_wren + 1;
      case (ram_rwtyp[1:0])
        2'b00:   mem[ram_addr[11:2]][8*ram_addr[1:0] +: 8] <= ram_data[7:0];
        2'b01:   mem[ram_addr[11:2]][16*ram_addr[1] +: 16] <= ram_data[15:0];
        default: mem[ram_addr[11:2]] <= ram_data;
      endcase
    end
    if (ram_rden) begin
      cnt_rden <= cnt_rden + 1;
      ram_q <= ramRead(mem[ram_addr[11:2]], ram_rwtyp, ram_addr[1:0]);
    end else begin
      ram_q <= 32'd0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction with rsp_ready=1, starting #1 after a clock edge
  // while the unit is idle; returns #1 after the handshake edge.
  task automatic applyStimulus(input string tag, input logic we,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input logic [31:0] exp_rdata,
                               input logic exp_exc, input logic [3:0] exp_cause);
    int lat;
    int wr0;
    int rd0;
    int exp_lat;
    exp_lat = (we || exp_exc) ? 1 : 2;
    wr0 = cnt_wren;
    rd0 = cnt_rden;
    rsp_ready  = 1'b1;
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
    checkOutput({tag, "_exc_cause"}, {27'd0, rsp_exc, rsp_cause},
                {27'd0, exp_exc, exp_cause});
    checkOutput({tag, "_rd"}, {27'd0, rsp_rd}, {27'd0, rd});
    checkOutput({tag, "_wren_cnt"}, cnt_wren - wr0, (we && !exp_exc) ? 1 : 0);
    checkOutput({tag, "_rden_cnt"}, cnt_rden - rd0, (!we && !exp_exc) ? 1 : 0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int c0;
    int wr0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[32'h100 >> 2] = 32'h80FF7F01;
    ram_q      = 32'd0;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 5'd0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    checkOutput("rst_exc_cause", {27'd0, rsp_exc, rsp_cause}, 32'd0);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Load extension from the preloaded word 0x80FF7F01 at 0x100.
    applyStimulus("lb_103",  1'b0, 3'b000, 32'h103, 32'd0, 5'd1, 32'hFFFFFF80, 1'b0, 4'd0);
    applyStimulus("lbu_103", 1'b0, 3'b100, 32'h103, 32'd0, 5'd2, 32'h00000080, 1'b0, 4'd0);
    applyStimulus("lb_101",  1'b0, 3'b000, 32'h101, 32'd0, 5'd3, 32'h0000007F, 1'b0, 4'd0);
    applyStimulus("lh_102",  1'b0, 3'b001, 32'h102, 32'd0, 5'd4, 32'hFFFF80FF, 1'b0, 4'd0);
    applyStimulus("lhu_102", 1'b0, 3'b101, 32'h102, 32'd0, 5'd5, 32'h000080FF, 1'b0, 4'd0);
    applyStimulus("lw_100",  1'b0, 3'b010, 32'h100, 32'd0, 5'd6, 32'h80FF7F01, 1'b0, 4'd0);

    // Store then load back.
    applyStimulus("sh_106",  1'b1, 3'b001, 32'h106, 32'h1234ABCD, 5'd7, 32'd0, 1'b0, 4'd0);
    applyStimulus("lw_104a", 1'b0, 3'b010, 32'h104, 32'd0, 5'd8, 32'hABCD0000, 1'b0, 4'd0);
    applyStimulus("sb_104",  1'b1, 3'b000, 32'h104, 32'h000000EE, 5'd9, 32'd0, 1'b0, 4'd0);
    applyStimulus("lw_104b", 1'b0, 3'b010, 32'h104, 32'd0, 5'd10, 32'hABCD00EE, 1'b0, 4'd0);

    // Exceptions.
    applyStimulus("lw_mis",    1'b0, 3'b010, 32'h102, 32'd0, 5'd11, 32'd0, 1'b1, 4'd4);
    applyStimulus("sh_mis",    1'b1, 3'b001, 32'h105, 32'h55, 5'd12, 32'd0, 1'b1, 4'd6);
    applyStimulus("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'd0, 5'd13, 32'd0, 1'b1, 4'd2);
    applyStimulus("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h77, 5'd14, 32'd0, 1'b1, 4'd2);
    applyStimulus("lw_fault",  1'b0, 3'b010, 32'h0004_0000, 32'd0, 5'd15, 32'd0, 1'b1, 4'd5);
    applyStimulus("sw_fault",  1'b1, 3'b010, 32'h0004_0000, 32'h99, 5'd16, 32'd0, 1'b1, 4'd7);
    applyStimulus("lw_last",   1'b0, 3'b010, 32'h3FFFC, 32'd0, 5'd17, 32'd0, 1'b0, 4'd0);

    // Backpressure: lb 0x103 held in RESP for 5 cycles.
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h103;
    req_rd     = 5'd18;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    wr0 = cnt_wren;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_rsp_rdata", rsp_rdata, 32'hFFFFFF80);
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
      if (i == 2) begin
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        req_wdata  = 32'hDEADBEEF;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
    checkOutput("bp_no_accept_wren", cnt_wren - wr0, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_no_extra_rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset while waiting for load data.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    req_rd     = 5'd19;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("rl_in_ld_wait", {31'd0, req_ready}, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rl_async", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rl_no_stale", {30'd0, rsp_valid, req_ready}, 32'd1);
    end
    applyStimulus("rl_lw_100", 1'b0, 3'b010, 32'h100, 32'd0, 5'd20, 32'h80FF7F01, 1'b0, 4'd0);

    // Back-to-back store/load pairs with rsp_ready tied high.
    for (int i = 0; i < 16; i++) begin
      c0 = cycle;
      applyStimulus("b2b_sw", 1'b1, 3'b010, 32'h200, i, 5'd21, 32'd0, 1'b0, 4'd0);
      applyStimulus("b2b_lw", 1'b0, 3'b010, 32'h200, 32'd0, 5'd22, i, 1'b0, 4'd0);
      checkOutput("b2b_pair_cycles", cycle - c0, 5);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
